// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  // Fetch FSM: FETCH has a request outstanding, HOLD parks a fetched word
  // during a stall, DROP waits out a response made stale by a flush.
  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_HOLD  = 2'd1,
    IF_DROP  = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Sequential PC step; the 32-bit result wraps naturally at 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a load enable and a flush-to-NOP input.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] inst,
  output logic [31:0] pc4,
  output logic        valid
);

  // Bubble takes priority over load so a flush never lets a word through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst  <= NOP_INST;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (bubble) begin
      inst  <= NOP_INST;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (load) begin
      inst  <= inst_in;
      pc4   <= pc4_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem request handshake, hold buffer for
// stalls, stale-response dropping for flushes, and the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        Flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] IF_ID_inst,
  output logic [31:0] IF_ID_pc4,
  output logic        IF_ID_valid,
  output logic        fetch_busy
);

  if_state_e   state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] hold, hold_next;
  logic [31:0] stale, stale_next;
  logic        ifid_load, ifid_bubble;
  logic [31:0] ifid_inst_in;
  logic        adv;

  assign adv = PCWrite & IF_ID_Write;

  // Next-state, PC and IF/ID control; Flush beats adv in every state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // can leave a signal unassigned and infer a latch.
    state_next   = state;
    pc_next      = pc;
    hold_next    = hold;
    stale_next   = stale;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;
    ifid_inst_in = imem_rdata;
    unique case (state)
      IF_FETCH: begin
        if (imem_ready) begin
          if (Flush) begin
            pc_next     = redirect_pc;
            ifid_bubble = 1'b1;
          end else if (adv) begin
            ifid_load = 1'b1;
            pc_next   = pc_plus4(pc);
          end else begin
            hold_next  = imem_rdata;
            state_next = IF_HOLD;
          end
        end else if (Flush) begin
          stale_next  = pc;
          pc_next     = redirect_pc;
          ifid_bubble = 1'b1;
          state_next  = IF_DROP;
        end else if (IF_ID_Write) begin
          ifid_bubble = 1'b1;
        end
      end
      IF_HOLD: begin
        ifid_inst_in = hold;
        if (Flush) begin
          pc_next     = redirect_pc;
          ifid_bubble = 1'b1;
          state_next  = IF_FETCH;
        end else if (adv) begin
          ifid_load  = 1'b1;
          pc_next    = pc_plus4(pc);
          state_next = IF_FETCH;
        end
      end
      IF_DROP: begin
        // The stale response is discarded; IF/ID stays a bubble meanwhile.
        if (Flush) begin
          pc_next     = redirect_pc;
          ifid_bubble = 1'b1;
        end else if (IF_ID_Write) begin
          ifid_bubble = 1'b1;
        end
        if (imem_ready) state_next = IF_FETCH;
      end
      default: state_next = IF_FETCH;
    endcase
  end

  // State, PC, hold buffer and stale-address registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state <= IF_FETCH;
      pc    <= RESET_PC;
      hold  <= 32'h0;
      stale <= 32'h0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      hold  <= hold_next;
      stale <= stale_next;
    end
  end

  assign imem_req   = !rst && (state != IF_HOLD);
  assign imem_addr  = (state == IF_DROP) ? stale : pc;
  assign fetch_busy = ((state == IF_FETCH) || (state == IF_DROP)) && !imem_ready;

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (ifid_load),
    .bubble  (ifid_bubble),
    .inst_in (ifid_inst_in),
    .pc4_in  (pc_plus4(pc)),
    .inst    (IF_ID_inst),
    .pc4     (IF_ID_pc4),
    .valid   (IF_ID_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios, then random
// stall/flush/wait-state traffic checked against a behavioural model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite, IF_ID_Write, Flush, imem_ready;
  logic [31:0] redirect_pc, imem_rdata, junk;
  logic        imem_req, IF_ID_valid, fetch_busy;
  logic [31:0] imem_addr, IF_ID_inst, IF_ID_pc4;

  // Second instance: wrap-around PC, zero-wait memory, never stalled.
  logic        w_req, w_valid, w_busy;
  logic [31:0] w_addr, w_inst, w_pc4, w_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  logic [31:0] m_pc, m_inst, m_pc4, m_buf, m_stale;
  logic        m_valid, m_buf_valid, m_drop;

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed, nonzero scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : junk;
  assign w_rdata    = mem_word(w_addr);

  if_stage dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .Flush(Flush), .redirect_pc(redirect_pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .IF_ID_inst(IF_ID_inst), .IF_ID_pc4(IF_ID_pc4), .IF_ID_valid(IF_ID_valid),
    .fetch_busy(fetch_busy)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .PCWrite(1'b1), .IF_ID_Write(1'b1),
    .Flush(1'b0), .redirect_pc(32'h0), .imem_req(w_req),
    .imem_addr(w_addr), .imem_rdata(w_rdata), .imem_ready(1'b1),
    .IF_ID_inst(w_inst), .IF_ID_pc4(w_pc4), .IF_ID_valid(w_valid),
    .fetch_busy(w_busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_buf = 32'h0; m_buf_valid = 1'b0; m_drop = 1'b0; m_stale = 32'h0;
  endtask

  task automatic model_nop();
    m_inst = 32'h0; m_valid = 1'b0;
  endtask

  task automatic model_load(input logic [31:0] w);
    m_inst = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
  endtask

  // One clock of the fetch rules, applied to the inputs present at the edge.
  task automatic model_step();
    logic adv;
    adv = PCWrite && IF_ID_Write;
    if (m_buf_valid) begin
      if (Flush) begin m_pc = redirect_pc; m_buf_valid = 1'b0; model_nop(); end
      else if (adv) begin model_load(m_buf); m_buf_valid = 1'b0; end
    end else if (m_drop) begin
      if (Flush) m_pc = redirect_pc;
      if (Flush || IF_ID_Write) model_nop();
      if (imem_ready) m_drop = 1'b0;
    end else if (imem_ready) begin
      if (Flush) begin m_pc = redirect_pc; model_nop(); end
      else if (adv) model_load(mem_word(m_pc));
      else begin m_buf = mem_word(m_pc); m_buf_valid = 1'b1; end
    end else if (Flush) begin
      m_stale = m_pc; m_pc = redirect_pc; m_drop = 1'b1; model_nop();
    end else if (IF_ID_Write) begin
      model_nop();
    end
  endtask

  task automatic compare_model();
    check("req", imem_req, !m_buf_valid);
    if (!m_buf_valid) check("addr", imem_addr, m_drop ? m_stale : m_pc);
    check("valid", IF_ID_valid, m_valid);
    check("inst", IF_ID_inst, m_inst);
    if (m_valid) check("pc4", IF_ID_pc4, m_pc4);
    check("busy", fetch_busy, !m_buf_valid && !imem_ready);
  endtask

  // Drive one cycle's inputs, clock, update the model, check #1 after the edge.
  task automatic cycle(input logic pw, input logic iw, input logic fl,
                       input logic rdy, input logic [31:0] rpc);
    PCWrite = pw; IF_ID_Write = iw; Flush = fl; imem_ready = rdy;
    redirect_pc = rpc; junk = $urandom;
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; PCWrite = 1'b1; IF_ID_Write = 1'b1; Flush = 1'b0;
    imem_ready = 1'b1; redirect_pc = 32'h0; junk = 32'h0;
    model_reset();
    #12 rst = 1'b0;
    #1;
    check("rst_inst", IF_ID_inst, 32'h0);
    check("rst_valid", IF_ID_valid, 1'b0);
    check("rst_pc4", IF_ID_pc4, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);

    // Zero-wait sequential fetch; wrap instance crosses 2^32 on first edge.
    cycle(1, 1, 0, 1, 0);
    check("seq_addr4", imem_addr, 32'h4);
    check("seq_pc4_4", IF_ID_pc4, 32'h4);
    check("seq_valid", IF_ID_valid, 1'b1);
    check("wrap_addr1", w_addr, 32'h0);
    check("wrap_pc4", w_pc4, 32'h0);
    check("wrap_inst", w_inst, mem_word(32'hFFFF_FFFC));
    cycle(1, 1, 0, 1, 0);
    check("seq_addr8", imem_addr, 32'h8);

    // Load-use stall at pc=8, then release.
    cycle(0, 0, 0, 1, 0);
    check("stall_inst", IF_ID_inst, mem_word(32'h4));
    check("stall_req", imem_req, 1'b0);
    cycle(1, 1, 0, 1, 0);
    check("rel_inst", IF_ID_inst, mem_word(32'h8));
    check("rel_pc4", IF_ID_pc4, 32'hC);
    check("rel_addr", imem_addr, 32'hC);
    cycle(1, 1, 0, 1, 0);

    // Flush to 0x40 at pc=0x10 with a zero-wait memory.
    cycle(1, 1, 1, 1, 32'h40);
    check("fl_valid", IF_ID_valid, 1'b0);
    check("fl_addr", imem_addr, 32'h40);
    cycle(1, 1, 0, 1, 0);
    check("fl_inst", IF_ID_inst, mem_word(32'h40));
    check("fl_pc4", IF_ID_pc4, 32'h44);

    // Flush while the request for 0x44 is outstanding; ready two cycles later.
    cycle(1, 1, 1, 0, 32'h40);
    check("drop_addr", imem_addr, 32'h44);
    cycle(1, 1, 0, 0, 0);
    check("drop_hold", imem_addr, 32'h44);
    cycle(1, 1, 0, 1, 0);
    check("drop_next", imem_addr, 32'h40);
    check("drop_valid", IF_ID_valid, 1'b0);
    cycle(1, 1, 0, 1, 0);
    check("drop_inst", IF_ID_inst, mem_word(32'h40));

    // Reset asserted asynchronously while parked in HOLD.
    cycle(0, 0, 0, 1, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_inst", IF_ID_inst, 32'h0);
    check("arst_valid", IF_ID_valid, 1'b0);
    check("arst_pc4", IF_ID_pc4, 32'h0);
    check("arst_req", imem_req, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("post_req", imem_req, 1'b1);
    check("post_addr", imem_addr, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      r[1:0] = 2'b00;
      cycle(($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 85),
            ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 70), r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
